// File: rtl/instruction_loader.sv
// instruction_loader: byte-stream program loader for the BIP2 instruction
// memory; holds the CPU in reset while words are written from address 0.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start_in            begins a load from IDLE or ERROR
//   byte_in/valid/ready stream byte handshake (transfer on valid && ready)
//   address_out         instruction memory write address
//   instruction_out     instruction memory write data
//   write_enable_out    one-cycle write strobe
//   cpu_hold_out        CPU reset hold, high whenever not IDLE
//   done_out            one-cycle pulse on a successful load
//   error_out           high while in ERROR (sticky until start_in or rst)
//
// Stream: 16-bit word count N (MSB first), N words of
// INSTRUCTION_WIDTH/8 bytes each (MSB first), then, when the
// INSTRUCTION_LOADER_CHECKSUM_EN macro is defined, one checksum byte that
// brings the 8-bit sum of all stream bytes to zero.
module instruction_loader #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ADDRESS_WIDTH     = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  output logic                         byte_ready_out,
  output logic [ADDRESS_WIDTH-1:0]     address_out,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic                         write_enable_out,
  output logic                         cpu_hold_out,
  output logic                         done_out,
  output logic                         error_out
);

  localparam int BYTES = INSTRUCTION_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  // Memory depth as a wide constant so the oversize compare never
  // overflows for any address width up to 32.
  localparam logic [32:0] DEPTH = 33'(1) << ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_WORD   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  // Where a stream goes once its last word (or an empty length) is seen.
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t state_q;
  state_t state_d;

  logic [7:0]                   len_hi_q;
  logic [15:0]                  remaining_q;
  logic [BCW-1:0]               byte_cnt_q;
  logic [ADDRESS_WIDTH-1:0]     addr_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;

  logic        fire;
  logic        start_ok;
  logic [15:0] len_word;
  logic        len_zero;
  logic        len_big;
  logic        last_byte;
  logic        last_word;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  assign sum_chk = sum_q + byte_in;
`endif

  assign fire      = byte_valid_in && byte_ready_out;
  assign start_ok  = start_in &&
                     (state_q == S_IDLE || state_q == S_ERROR);
  assign len_word  = {len_hi_q, byte_in};
  assign len_zero  = (len_word == 16'd0);
  assign len_big   = ({17'd0, len_word} > DEPTH);
  assign last_byte = (byte_cnt_q == BCW'(BYTES - 1));
  assign last_word = (remaining_q == 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    byte_ready_out   = 1'b0;
    write_enable_out = 1'b0;
    cpu_hold_out     = 1'b1;
    done_out         = 1'b0;
    error_out        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cpu_hold_out = 1'b0;
        if (start_in) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in) begin
          unique case (1'b1)
            len_zero: state_d = S_END;
            len_big:  state_d = S_ERROR;
            default:  state_d = S_WORD;
          endcase
        end
      end
      S_WORD: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in && last_byte) state_d = S_WRITE;
      end
      S_WRITE: begin
        write_enable_out = 1'b1;
        state_d = last_word ? S_END : S_WORD;
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in) begin
          state_d = (sum_chk == 8'd0) ? S_DONE : S_ERROR;
        end
      end
`endif
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERROR: begin
        error_out = 1'b1;
        if (start_in) state_d = S_LEN_HI;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q    <= '0;
      remaining_q <= '0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      instr_q     <= '0;
    end else if (state_q == S_IDLE || start_ok) begin
      byte_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        S_LEN_HI: begin
          if (fire) len_hi_q <= byte_in;
        end
        S_LEN_LO: begin
          if (fire) remaining_q <= len_word;
        end
        S_WORD: begin
          if (fire) begin
            instr_q    <= INSTRUCTION_WIDTH'({instr_q, byte_in});
            byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
          end
        end
        S_WRITE: begin
          addr_q      <= addr_q + 1'b1;
          remaining_q <= remaining_q - 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  // Running sum covers length and data bytes; the checksum byte itself
  // is only added combinationally in CHECK.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == S_IDLE || start_ok) begin
      sum_q <= '0;
    end else if (fire && state_q != S_CHECK) begin
      sum_q <= sum_q + byte_in;
    end
  end
`endif

  assign address_out     = addr_q;
  assign instruction_out = instr_q;

endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: scoreboard bench for instruction_loader.
// Streams are modelled as byte lists; expected writes/events are queued.
module tb_instruction_loader;

  localparam int IW    = 16;
  localparam int AW    = 11;
  localparam int BYTES = IW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_in = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid_in = 1'b0;
  logic          byte_ready_out;
  logic [AW-1:0] address_out;
  logic [IW-1:0] instruction_out;
  logic          write_enable_out;
  logic          cpu_hold_out;
  logic          done_out;
  logic          error_out;

  always #5 clk = ~clk;

  instruction_loader #(
    .INSTRUCTION_WIDTH(IW),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out),
    .address_out(address_out),
    .instruction_out(instruction_out),
    .write_enable_out(write_enable_out),
    .cpu_hold_out(cpu_hold_out),
    .done_out(done_out),
    .error_out(error_out)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  int   checks = 0;
  int   failures = 0;
  wr_t  exp_wr[$];
  int   exp_ev[$];
  wr_t  mon_e;
  logic err_q = 1'b0;
  bit   rand_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event codes: 0 = done pulse, 1 = entry into ERROR.
  task automatic pop_event(input int code);
    if (exp_ev.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got code %0d expected none", code);
    end else begin
      chk("event", code, exp_ev.pop_front());
    end
  endtask

  always @(negedge clk) begin
    err_q <= error_out;
    if (write_enable_out) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 address_out, instruction_out);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("write_addr", 32'(address_out), 32'(mon_e.a));
        chk("write_data", 32'(instruction_out), 32'(mon_e.d));
      end
    end
    if (done_out) pop_event(0);
    if (error_out && !err_q) pop_event(1);
  end

  function automatic logic [7:0] cks(input logic [7:0] b[$]);
    int s;
    s = 0;
    foreach (b[i]) s += int'(b[i]);
    return 8'(-s);
  endfunction

  // Reference model: interpret the byte list as a whole stream.
  task automatic model(input logic [7:0] b[$], output bit exp_err);
    int n;
    int s;
    logic [IW-1:0] w;
    wr_t e;
    exp_err = 1'b0;
    n = int'({b[0], b[1]});
    if (n > DEPTH) begin
      exp_ev.push_back(1);
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < BYTES; k++) w = (w << 8) | IW'(b[2 + i*BYTES + k]);
      e.a = AW'(i % DEPTH);
      e.d = w;
      exp_wr.push_back(e);
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    s = 0;
    for (int j = 0; j < b.size(); j++) s += int'(b[j]);
    if ((s % 256) == 0) exp_ev.push_back(0);
    else begin
      exp_ev.push_back(1);
      exp_err = 1'b1;
    end
`else
    s = 0;
    exp_ev.push_back(s);
`endif
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      byte_valid_in = 1'b0;
      byte_in = 8'($urandom);
      start_in = 1'b0;
    end
    @(negedge clk);
    byte_valid_in = 1'b1;
    byte_in = v;
    start_in = rand_start && ($urandom_range(0, 3) == 0);
    n = 0;
    while (!byte_ready_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got ready 0 for 100 cycles expected 1");
    end
  endtask

  task automatic end_stream();
    @(negedge clk);
    byte_valid_in = 1'b0;
    start_in = 1'b0;
  endtask

  task automatic begin_load();
    @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("ready_after_start", byte_ready_out, 1);
    chk("error_cleared", error_out, 0);
  endtask

  task automatic settle(input bit exp_err);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_ev.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL settle_timeout: got %0d writes %0d events pending expected 0",
               exp_wr.size(), exp_ev.size());
    end
    @(negedge clk);
    if (exp_err) begin
      chk("error_level", error_out, 1);
      chk("hold_in_error", cpu_hold_out, 1);
    end else begin
      chk("hold_released", cpu_hold_out, 0);
    end
  endtask

  function automatic int gap_of(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic body(input logic [7:0] b[$], input int mode,
                      input bit e);
    foreach (b[i]) send_byte(b[i], gap_of(mode));
    end_stream();
    settle(e);
  endtask

  task automatic run_stream(input logic [7:0] b[$], input int mode);
    bit e;
    model(b, e);
    begin_load();
    body(b, mode, e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, byte_ready_out, 0);
    chk({tag, "_addr"}, 32'(address_out), 0);
    chk({tag, "_instr"}, 32'(instruction_out), 0);
    chk({tag, "_we"}, write_enable_out, 0);
    chk({tag, "_hold"}, cpu_hold_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_error"}, error_out, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] basic[$];
    bit e;
    int n;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    basic = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    basic.push_back(cks(basic));
`endif

    // Basic load with cycle-level timing checks.
    model(basic, e);
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(negedge clk);
    chk("we_after_word", write_enable_out, 1);
    chk("ready_low_in_write", byte_ready_out, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(basic[6], 0);
    end_stream();
`else
    end_stream();
    chk("we_second_word", write_enable_out, 1);
    @(negedge clk);
`endif
    chk("done_pulse", done_out, 1);
    settle(e);

    // Back-pressure: valid toggles every other cycle.
    run_stream(basic, 1);

    // Empty stream.
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    run_stream('{8'h00, 8'h00, 8'h00}, 0);
`else
    bq = '{8'h00, 8'h00};
    model(bq, e);
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    end_stream();
    chk("done_after_empty", done_out, 1);
    settle(e);
`endif

    // Oversize length.
    bq = '{8'h08, 8'h01};
    model(bq, e);
    begin_load();
    send_byte(8'h08, 0);
    send_byte(8'h01, 0);
    end_stream();
    chk("error_after_oversize", error_out, 1);
    chk("no_write_oversize", write_enable_out, 0);
    repeat (4) @(negedge clk);
    settle(e);

    // Start from ERROR clears the error and loads normally.
    model(basic, e);
    begin_load();
    body(basic, 0, e);

    // Reset in the middle of a load.
    begin_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    @(negedge clk);
    byte_valid_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    run_stream(basic, 0);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    run_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'hBA}, 0);
    run_stream('{8'h00, 8'h01, 8'h12, 8'h34, 8'hBB}, 0);
`endif

    // Full-depth load: address wraps, no extra write.
    bq = '{8'((DEPTH >> 8) & 255), 8'(DEPTH & 255)};
    for (int i = 0; i < DEPTH * BYTES; i++) bq.push_back(8'($urandom));
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    bq.push_back(cks(bq));
`endif
    run_stream(bq, 0);

    // Randomised streams with start_in noise mid-load.
    rand_start = 1'b1;
    for (int it = 0; it < 30; it++) begin
      bq.delete();
      if ($urandom_range(0, 9) == 0) begin
        n = int'($urandom_range(DEPTH + 1, 65535));
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
      end else begin
        n = int'($urandom_range(0, 5));
        bq.push_back(8'(n >> 8));
        bq.push_back(8'(n));
        for (int i = 0; i < n * BYTES; i++) bq.push_back(8'($urandom));
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) bq.push_back(8'(cks(bq) + 8'd1));
        else bq.push_back(cks(bq));
`endif
      end
      run_stream(bq, int'($urandom_range(0, 2)));
    end
    rand_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
